// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store sequencer in front of a single-port,
// combinational-read word memory (data_mem).
//   clk, rst_n                  : clock, asynchronous active-low reset
//   req_valid/req_ready         : request handshake (ready only in IDLE)
//   req_we, req_funct3          : direction and RV32I width code
//   req_addr, req_wdata         : byte address, right-aligned store data
//   resp_valid/resp_rdata/resp_err : one-cycle completion with extended load data
//   mem_addr, mem_write_data, cs_mem_write, mem_read_data : data_mem port
module load_store_unit #(
    parameter int unsigned MEM_DEPTH  = 256,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [31:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  cs_mem_write,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic            ready_q, ready_d;
    logic            we_q, we_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            resp_valid_q, resp_valid_d;
    logic [DW-1:0]   resp_rdata_q, resp_rdata_d;
    logic            resp_err_q, resp_err_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic            cs_q, cs_d;

    logic            req_err_c;
    logic            funct3_legal_c;
    logic            misaligned_c;
    logic            out_of_range_c;
    logic [4:0]      lane_shift_c;
    logic [DW-1:0]   lane_c;
    logic [DW-1:0]   load_data_c;
    logic [DW-1:0]   lane_mask_c;
    logic [DW-1:0]   merged_c;

    // Request legality, evaluated on the incoming (not yet latched) request
    always_comb begin
        funct3_legal_c = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: funct3_legal_c = 1'b1;
            3'b100, 3'b101:         funct3_legal_c = !req_we;
            default:                funct3_legal_c = 1'b0;
        endcase
        misaligned_c   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        out_of_range_c = {2'b00, req_addr[AW-1:2]} >= AW'(MEM_DEPTH);
        req_err_c      = !funct3_legal_c || misaligned_c || out_of_range_c;
    end

    // Lane extraction for loads and lane merge for sub-word stores
    always_comb begin
        lane_shift_c = {addr_q[1:0], 3'b000};
        lane_c       = mem_read_data >> lane_shift_c;
        case (funct3_q)
            3'b000:  load_data_c = {{(DW-8){lane_c[7]}}, lane_c[7:0]};
            3'b001:  load_data_c = {{(DW-16){lane_c[15]}}, lane_c[15:0]};
            3'b100:  load_data_c = {{(DW-8){1'b0}}, lane_c[7:0]};
            3'b101:  load_data_c = {{(DW-16){1'b0}}, lane_c[15:0]};
            default: load_data_c = mem_read_data;
        endcase
        case (funct3_q[1:0])
            2'b00:   lane_mask_c = DW'(8'hFF);
            2'b01:   lane_mask_c = DW'(16'hFFFF);
            default: lane_mask_c = {DW{1'b1}};
        endcase
        merged_c = (mem_read_data & ~(lane_mask_c << lane_shift_c)) |
                   ((wdata_q & lane_mask_c) << lane_shift_c);
    end

    // Next-state and next-output logic; every output is registered
    always_comb begin
        state_d      = state_q;
        ready_d      = ready_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cs_d         = cs_q;

        case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    we_d       = req_we;
                    funct3_d   = req_funct3;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    mem_addr_d = {2'b00, req_addr[AW-1:2]};
                    ready_d    = 1'b0;
                    if (req_err_c) begin
                        state_d      = DONE;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else if (!req_we) begin
                        state_d = LOAD;
                    end else if (req_funct3 == 3'b010) begin
                        // Full word: no read needed, write straight away
                        state_d     = WRITE;
                        cs_d        = 1'b1;
                        mem_wdata_d = req_wdata;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LOAD: begin
                state_d      = DONE;
                mem_addr_d   = {2'b00, addr_q[AW-1:2]};
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = we_q ? '0 : load_data_c;
            end
            RMW_RD: begin
                state_d     = WRITE;
                mem_addr_d  = {2'b00, addr_q[AW-1:2]};
                cs_d        = 1'b1;
                mem_wdata_d = merged_c;
            end
            WRITE: begin
                state_d      = DONE;
                mem_addr_d   = {2'b00, addr_q[AW-1:2]};
                cs_d         = 1'b0;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = '0;
            end
            DONE: begin
                state_d      = IDLE;
                ready_d      = 1'b1;
                resp_valid_d = 1'b0;
                resp_err_d   = 1'b0;
                resp_rdata_d = '0;
                mem_addr_d   = '0;
            end
            default: begin
                state_d      = IDLE;
                ready_d      = 1'b1;
                resp_valid_d = 1'b0;
                resp_err_d   = 1'b0;
                resp_rdata_d = '0;
                mem_addr_d   = '0;
                cs_d         = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            we_q         <= 1'b0;
            funct3_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cs_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cs_q         <= cs_d;
        end
    end

    assign req_ready      = ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign resp_err       = resp_err_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_wdata_q;
    assign cs_mem_write   = cs_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: acts as data_mem and compares against a
// byte-addressed reference memory model.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        cs_mem_write;
    logic [31:0] mem_read_data;

    int checks = 0;
    int errors = 0;

    // data_mem stand-in, preloaded through a private port while in reset
    logic [31:0] dmem [256];
    logic        init_we;
    logic [7:0]  init_idx;
    logic [31:0] init_data;

    // Reference model: plain byte array, little-endian
    logic [7:0]  ref_b [1024];

    load_store_unit #(.MEM_DEPTH(256), .DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .mem_addr      (mem_addr),
        .mem_write_data(mem_write_data),
        .cs_mem_write  (cs_mem_write),
        .mem_read_data (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_read_data = (mem_addr < 32'd256) ? dmem[mem_addr[7:0]] : 32'h0;

    always @(posedge clk) begin
        if (init_we)
            dmem[init_idx] <= init_data;
        else if (cs_mem_write && (mem_addr < 32'd256))
            dmem[mem_addr[7:0]] <= mem_write_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int unsigned idx);
        return {ref_b[idx*4+3], ref_b[idx*4+2], ref_b[idx*4+1], ref_b[idx*4]};
    endfunction

    // Request-level model: legality, result, latency, writes; applies stores
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic err, output logic [31:0] rd,
                         output int lat, output int nwr);
        int unsigned size;
        logic [31:0] v;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        if (we && f3[2]) size = 0;
        err = (size == 0) || ((addr % size) != 0) || ((addr / 4) >= 256);
        rd  = 32'h0;
        if (err) begin
            lat = 1;
            nwr = 0;
        end else if (we) begin
            for (int i = 0; i < int'(size); i++) ref_b[int'(addr) + i] = wd[8*i +: 8];
            lat = (size == 4) ? 2 : 3;
            nwr = 1;
        end else begin
            v = 32'h0;
            for (int i = 0; i < int'(size); i++) v = v | (32'(ref_b[int'(addr) + i]) << (8*i));
            if (f3 == 3'd0 && v[7])  v = v | 32'hFFFFFF00;
            if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
            rd  = v;
            lat = 2;
            nwr = 0;
        end
    endtask

    // One complete request: drive, observe every busy cycle, compare to model
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] got);
        logic        e_err;
        logic [31:0] e_rd;
        int          e_lat, e_nwr, cyc, nwr;
        bit          seen;
        model(we, f3, addr, wd, e_err, e_rd, e_lat, e_nwr);
        @(negedge clk);
        check("idle_ready", 32'(req_ready), 32'd1);
        check("idle_mem_addr", mem_addr, 32'h0);
        check("idle_resp_valid", 32'(resp_valid), 32'd0);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        cyc = 0; nwr = 0; seen = 0; got = 32'h0;
        while (!seen && cyc < 8) begin
            @(negedge clk);
            cyc++;
            req_valid  = 1'b0;
            req_we     = 1'($urandom);
            req_funct3 = 3'($urandom);
            req_addr   = $urandom;
            req_wdata  = $urandom;
            check("busy_ready", 32'(req_ready), 32'd0);
            check("busy_mem_addr", mem_addr, addr >> 2);
            if (cs_mem_write) begin
                nwr++;
                if ((addr >> 2) < 256) check("write_data", mem_write_data, ref_word(addr >> 2));
            end
            if (resp_valid) begin
                seen = 1;
                got  = resp_rdata;
                check("resp_rdata", resp_rdata, e_rd);
                check("resp_err", 32'(resp_err), 32'(e_err));
                check("latency", 32'(cyc), 32'(e_lat));
            end
        end
        if (!seen) check("resp_timeout", 32'd0, 32'd1);
        check("write_count", 32'(nwr), 32'(e_nwr));
    endtask

    initial begin
        logic [31:0] g;
        logic [31:0] w;
        logic [31:0] pre;
        logic        h_err;
        logic [31:0] h_rd;
        int          h_lat, h_nwr, nresp, ncs;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0;
        init_we = 1'b0; init_idx = 8'd0; init_data = 32'h0;

        // Preload memory and model with identical random contents
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            w = $urandom;
            init_we = 1'b1; init_idx = 8'(i); init_data = w;
            for (int b = 0; b < 4; b++) ref_b[i*4 + b] = w[8*b +: 8];
        end
        @(negedge clk);
        init_we = 1'b0;
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_cs", 32'(cs_mem_write), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_rdata", resp_rdata, 32'h0);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'd1);

        // Word store then word load
        do_req(1'b1, 3'd2, 32'hA8, 32'hDEADBEEF, g);
        check("sw_mem42", dmem[42], 32'hDEADBEEF);
        do_req(1'b0, 3'd2, 32'hA8, 32'h0, g);
        check("lw_a8", g, 32'hDEADBEEF);

        // Byte store and byte loads
        do_req(1'b1, 3'd0, 32'hA9, 32'h000000A5, g);
        check("sb_mem42", dmem[42], 32'hDEADA5EF);
        do_req(1'b0, 3'd0, 32'hA9, 32'h0, g);
        check("lb_a9", g, 32'hFFFFFFA5);
        do_req(1'b0, 3'd4, 32'hA9, 32'h0, g);
        check("lbu_a9", g, 32'h000000A5);

        // Half store and half loads
        do_req(1'b1, 3'd1, 32'hAA, 32'h00001234, g);
        check("sh_mem42", dmem[42], 32'h1234A5EF);
        do_req(1'b0, 3'd1, 32'hAA, 32'h0, g);
        check("lh_aa", g, 32'h00001234);
        do_req(1'b0, 3'd5, 32'hA8, 32'h0, g);
        check("lhu_a8", g, 32'h0000A5EF);

        // Error requests leave memory untouched
        do_req(1'b0, 3'd1, 32'hA9, 32'h0, g);
        check("err_lh_rdata", g, 32'h0);
        do_req(1'b1, 3'd2, 32'hAA, 32'h55555555, g);
        check("err_sw_rdata", g, 32'h0);
        do_req(1'b0, 3'd3, 32'hA8, 32'h0, g);
        check("err_f3_rdata", g, 32'h0);
        do_req(1'b0, 3'd2, 32'h400, 32'h0, g);
        check("err_range_rdata", g, 32'h0);
        check("err_mem42", dmem[42], 32'h1234A5EF);

        // Reset during RMW_RD: no write, outputs cleared, ready on release
        pre = ref_word(42);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0;
        req_addr = 32'hA8; req_wdata = 32'h0000005A;
        @(negedge clk);
        req_valid = 1'b0;
        check("rmw_busy", 32'(req_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cs", 32'(cs_mem_write), 32'd0);
        check("arst_resp_valid", 32'(resp_valid), 32'd0);
        check("arst_resp_err", 32'(resp_err), 32'd0);
        check("arst_rdata", resp_rdata, 32'h0);
        check("arst_mem_addr", mem_addr, 32'h0);
        check("arst_wdata", mem_write_data, 32'h0);
        ncs = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (cs_mem_write) ncs++;
        end
        rst_n = 1'b1;
        #1;
        check("arst_release_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        if (cs_mem_write) ncs++;
        check("arst_no_cs", 32'(ncs), 32'd0);
        check("arst_no_resp", 32'(resp_valid), 32'd0);
        check("arst_mem42", dmem[42], pre);

        // req_valid held through loads: one accept per IDLE cycle only
        model(1'b0, 3'd2, 32'hA8, 32'h0, h_err, h_rd, h_lat, h_nwr);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2;
        req_addr = 32'hA8; req_wdata = 32'h0;
        nresp = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check("hold_ready", 32'(req_ready), (k % 3 == 0) ? 32'd1 : 32'd0);
            check("hold_resp_valid", 32'(resp_valid), (k % 3 == 2) ? 32'd1 : 32'd0);
            if (resp_valid) begin
                nresp++;
                check("hold_rdata", resp_rdata, h_rd);
            end
        end
        req_valid = 1'b0;
        check("hold_resp_count", 32'(nresp), 32'd3);

        // Randomized traffic against the model
        for (int n = 0; n < 200; n++) begin
            we = 1'($urandom);
            f3 = 3'($urandom);
            if ($urandom_range(0, 15) == 0) addr = 32'h400 + 32'($urandom_range(0, 255));
            else addr = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b01) addr = addr & ~32'h1;
                if (f3[1:0] == 2'b10) addr = addr & ~32'h3;
            end
            do_req(we, f3, addr, $urandom, g);
        end

        // Final memory image
        @(negedge clk);
        for (int i = 0; i < 256; i++) check("final_mem", dmem[i], ref_word(i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, number of 32-bit words in the attached data_mem.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width; only 32 is supported.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 1, core presents a request.
REQ-006 SHALL have port req_ready, output, 1, unit can accept a request.
REQ-007 SHALL have port req_we, input, 1; 1 = store, 0 = load.
REQ-008 SHALL have port req_funct3, input, 3, RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 SHALL have port req_addr, input, 32, byte address.
REQ-010 SHALL have port req_wdata, input, 32, store data, right-aligned.
REQ-011 SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata, output, 32, extended load result; 0 for stores and errors.
REQ-013 SHALL have port resp_err, output, 1, misaligned, out-of-range or illegal request; valid with resp_valid.
REQ-014 SHALL have port mem_addr, output, 32, word index to data_mem addr (byte_addr >> 2).
REQ-015 SHALL have port mem_write_data, output, 32, to data_mem write_data.
REQ-016 SHALL have port cs_mem_write, output, 1, to data_mem cs_mem_write; write occurs on the rising edge while high.
REQ-017 SHALL have port mem_read_data, input, 32, from data_mem read_data; combinational function of mem_addr.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, RMW_RD, WRITE, DONE.
REQ-019 SHALL drive req_ready = 1 only in IDLE; a request is accepted on a rising edge with req_valid && req_ready, latching req_we, req_funct3, req_addr and req_wdata.
REQ-020 SHALL flag an error on acceptance if any of the following hold: funct3 is not legal for the direction (stores allow only 000/001/010), H/HU with addr[0]=1, W with addr[1:0]!=0, or addr>>2 >= MEM_DEPTH.
REQ-021 SHALL route an error request IDLE->DONE with no memory access and resp_err=1.
REQ-022 SHALL route a load IDLE->LOAD->DONE; in LOAD it captures mem_read_data, selects the byte or half by addr[1:0], and sign-extends (B,H) or zero-extends (BU,HU,W).
REQ-023 SHALL route a word store IDLE->WRITE->DONE, with cs_mem_write=1 for exactly the WRITE cycle and mem_write_data=req_wdata.
REQ-024 SHALL route a byte or half store IDLE->RMW_RD->WRITE->DONE; in RMW_RD it captures mem_read_data and replaces only the addressed lane(s) with the low bits of req_wdata, then WRITE writes the merged word.
REQ-025 SHALL hold mem_addr at the latched word index in every non-IDLE state, and at 0 in IDLE.
REQ-026 SHALL assert resp_valid only in DONE, for exactly one cycle, then return to IDLE; the next accept is possible on the following edge.
REQ-027 SHALL give these latencies (accept edge to resp_valid high): load 2 cycles, word store 2, sub-word store 3, error 1.
REQ-028 SHALL never assert cs_mem_write outside WRITE.
REQ-029 SHALL ignore req_valid when req_ready=0 (no queuing).

Reset
REQ-030 SHALL, while rst_n=0 (asynchronously), force state=IDLE, cs_mem_write=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_addr=0, mem_write_data=0 and all latched request fields to 0.
REQ-031 SHALL discard an in-flight operation on reset: no write, no response.
REQ-032 SHALL assert req_ready=1 on the first cycle after rst_n rises.

Verification
REQ-033 SHALL cover: SW 0xDEADBEEF @0xA8 -> cs_mem_write high for one cycle with mem_addr=42; then LW @0xA8 -> resp_rdata=0xDEADBEEF, 2 cycles after accept.
REQ-034 SHALL cover: SB 0x000000A5 @0xA9 -> word 42 = 0xDEADA5EF, resp_valid 3 cycles after accept; LB @0xA9 -> 0xFFFFFFA5; LBU @0xA9 -> 0x000000A5.
REQ-035 SHALL cover: SH 0x00001234 @0xAA -> word 42 = 0x1234A5EF; LH @0xAA -> 0x00001234; LHU @0xA8 -> 0x0000A5EF.
REQ-036 SHALL cover: LH @0xA9, SW @0xAA, funct3=011, and LW @0x400 (word 256) -> resp_err=1 one cycle after accept, resp_rdata=0, cs_mem_write never high, memory unchanged.
REQ-037 SHALL cover: SB @0xA8 with rst_n pulsed low during RMW_RD -> all outputs 0 immediately, no write, word 42 unchanged, req_ready=1 the first cycle after release.
REQ-038 SHALL cover: req_valid held high through a load -> exactly one request accepted per IDLE cycle, and none while req_ready=0.
